// File: rtl/mole_game_fsm.sv
// Whack-A-Mole round controller: random hole per round, hit/miss/timeout judging, score tally.
// Optional STRICT_PENALTY_EN: a wrong press in UP counts as a miss and ends the round.
module mole_game_fsm #(
  parameter int unsigned NUM_HOLES  = 4,
  parameter int unsigned UP_CYCLES  = 1000,
  parameter int unsigned GAP_CYCLES = 200,
  parameter int unsigned ROUNDS     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit_pulse,
  output logic [NUM_HOLES-1:0] mole,
  output logic [7:0]           score,
  output logic [7:0]           misses,
  output logic                 busy,
  output logic                 game_over
);

  localparam int unsigned HW   = $clog2(NUM_HOLES);
  localparam int unsigned TMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] UP_LOAD    = TW'(UP_CYCLES - 1);
  localparam logic [7:0]    ROUNDS_END = 8'(ROUNDS);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [7:0]           round_q, round_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic [7:0]           score_q, score_d;
  logic [7:0]           misses_q, misses_d;
  logic                 busy_q, busy_d;
  logic                 over_q, over_d;
  logic                 end_round;
  logic [7:0]           round_inc;

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      round_q  <= '0;
      lfsr_q   <= 8'hA5;
      mole_q   <= '0;
      score_q  <= '0;
      misses_q <= '0;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      round_q  <= round_d;
      lfsr_q   <= lfsr_d;
      mole_q   <= mole_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    round_d   = round_q;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    mole_d    = mole_q;
    score_d   = score_q;
    misses_d  = misses_q;
    busy_d    = busy_q;
    over_d    = over_q;
    end_round = 1'b0;
    round_inc = round_q + 8'd1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_d  = '0;
          misses_d = '0;
          round_d  = '0;
          timer_d  = GAP_LOAD;
          busy_d   = 1'b1;
          over_d   = 1'b0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          mole_d  = NUM_HOLES'(1) << lfsr_q[HW-1:0];
          timer_d = UP_LOAD;
          state_d = S_UP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_UP: begin
        // A hit wins over a simultaneous timeout
        if (hit_pulse == mole_q) begin
          score_d   = score_q + 8'd1;
          end_round = 1'b1;
        end
`ifdef STRICT_PENALTY_EN
        else if (hit_pulse != '0) begin
          misses_d  = misses_q + 8'd1;
          end_round = 1'b1;
        end
`endif
        else if (timer_q == '0) begin
          misses_d  = misses_q + 8'd1;
          end_round = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end

        if (end_round) begin
          mole_d  = '0;
          round_d = round_inc;
          if (round_inc == ROUNDS_END) begin
            busy_d  = 1'b0;
            over_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            timer_d = GAP_LOAD;
            state_d = S_GAP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mole      = mole_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign busy      = busy_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_mole_game_fsm.sv
// Self-checking bench for mole_game_fsm: round-level timing model plus reference LFSR.
module tb_mole_game_fsm;
  localparam int unsigned NH   = 4;
  localparam int unsigned UPC  = 20;
  localparam int unsigned GAPC = 5;
  localparam int unsigned RND  = 4;
`ifdef STRICT_PENALTY_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NH-1:0] hit_pulse = '0;
  logic [NH-1:0] mole;
  logic [7:0]    score, misses;
  logic          busy, game_over;

  int total = 0;
  int bad   = 0;
  int exp_score, exp_misses, exp_rounds;
  logic [7:0] lfsr_m;

  mole_game_fsm #(
    .NUM_HOLES (NH),
    .UP_CYCLES (UPC),
    .GAP_CYCLES(GAPC),
    .ROUNDS    (RND)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .hit_pulse(hit_pulse),
    .mole     (mole),
    .score    (score),
    .misses   (misses),
    .busy     (busy),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Reference LFSR: taps 7,5,4,3, free-running, reseeded only by reset
  always @(posedge clock) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_game();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    exp_score = 0; exp_misses = 0; exp_rounds = 0;
    total++;
    if (busy !== 1'b1 || game_over !== 1'b0 || score !== 8'd0 || misses !== 8'd0 || mole !== '0) begin
      bad++;
      $display("FAIL start_game: busy=%b over=%b score=%0d misses=%0d mole=%b want 1 0 0 0 0",
               busy, game_over, score, misses, mole);
    end
  endtask

  // Entered in the first GAP cycle; leaves just after the round-ending edge.
  task automatic run_round(input int correct_at, input int wrong_at, input int start_gap,
                           input bit gap_noise);
    logic [NH-1:0] exp_mole;
    logic [NH-1:0] wpat;
    bit done_r;
    int u;
    exp_mole = '0;
    for (int g = 1; g <= int'(GAPC); g++) begin
      total++;
      if (mole !== '0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL gap_phase g=%0d: mole=%b busy=%b want mole=0 busy=1", g, mole, busy);
      end
      if (g == int'(GAPC)) exp_mole = NH'(1) << lfsr_m[1:0];
      if (g == start_gap) start = 1'b1;
      if (gap_noise) hit_pulse = NH'($urandom_range(0, 15));
      @(negedge clock);
      start = 1'b0;
      hit_pulse = '0;
    end
    do wpat = NH'($urandom_range(1, 15)); while (wpat == exp_mole);
    done_r = 1'b0;
    u = 0;
    while (!done_r && u < int'(UPC)) begin
      total++;
      if (mole !== exp_mole) begin
        bad++;
        $display("FAIL mole_up u=%0d: mole=%b want %b", u, mole, exp_mole);
      end
      if (u == correct_at)    hit_pulse = exp_mole;
      else if (u == wrong_at) hit_pulse = wpat;
      @(negedge clock);
      hit_pulse = '0;
      if (u == correct_at) begin
        exp_score++;
        done_r = 1'b1;
      end else if (u == wrong_at && STRICT) begin
        exp_misses++;
        done_r = 1'b1;
      end
      u++;
    end
    if (!done_r) exp_misses++;
    exp_rounds++;
    total++;
    if (mole !== '0 || score !== 8'(exp_score) || misses !== 8'(exp_misses)) begin
      bad++;
      $display("FAIL round_end r=%0d: mole=%b score=%0d misses=%0d want 0 %0d %0d",
               exp_rounds, mole, score, misses, exp_score, exp_misses);
    end
    total++;
    if (game_over !== (exp_rounds == int'(RND)) || busy !== (exp_rounds != int'(RND))) begin
      bad++;
      $display("FAIL round_flags r=%0d: over=%b busy=%b want %b %b", exp_rounds, game_over,
               busy, exp_rounds == int'(RND), exp_rounds != int'(RND));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; hit_pulse = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      total++;
      if (mole !== '0 || busy !== 1'b0 || score !== 8'd0 || misses !== 8'd0 || game_over !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset c=%0d: mole=%b busy=%b score=%0d misses=%0d over=%b want all 0",
                 i, mole, busy, score, misses, game_over);
      end
      hit_pulse = NH'($urandom_range(0, 15));
      @(negedge clock);
      hit_pulse = '0;
    end
  endtask

  task automatic test_timeout();
    start_game();
    for (int r = 0; r < int'(RND); r++) run_round(-1, -1, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      hit_pulse = NH'($urandom_range(1, 15));
      @(negedge clock);
      hit_pulse = '0;
      total++;
      if (score !== 8'd0 || misses !== 8'd4 || game_over !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL done_hold: score=%0d misses=%0d over=%b busy=%b want 0 4 1 0",
                 score, misses, game_over, busy);
      end
    end
  endtask

  task automatic test_hit();
    start_game();
    for (int r = 0; r < int'(RND); r++) run_round(3, -1, 0, 1'b0);
    total++;
    if (score !== 8'd4 || misses !== 8'd0 || game_over !== 1'b1) begin
      bad++;
      $display("FAIL hit_game: score=%0d misses=%0d over=%b want 4 0 1", score, misses, game_over);
    end
  endtask

  task automatic test_wrong_press();
    start_game();
    run_round(-1, 2, 0, 1'b0);
    total++;
    if (misses !== 8'd1 || score !== 8'd0) begin
      bad++;
      $display("FAIL wrong_press: misses=%0d score=%0d want 1 0", misses, score);
    end
    for (int r = 1; r < int'(RND); r++) run_round(int'(UPC) - 1, -1, 0, 1'b0);
    total++;
    if (score !== 8'd3 || misses !== 8'd1 || game_over !== 1'b1) begin
      bad++;
      $display("FAIL last_cycle_hit: score=%0d misses=%0d over=%b want 3 1 1",
               score, misses, game_over);
    end
  endtask

  task automatic test_reset_mid_up();
    start_game();
    run_round(1, -1, 0, 1'b0);
    run_round(1, -1, 0, 1'b0);
    repeat (GAPC + 2) @(negedge clock);
    total++;
    if (!$onehot(mole) || score !== 8'd2) begin
      bad++;
      $display("FAIL pre_reset: mole=%b score=%0d want one-hot and 2", mole, score);
    end
    reset = 1'b1;
    hit_pulse = '1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    hit_pulse = '0;
    start = 1'b0;
    total++;
    if (mole !== '0 || score !== 8'd0 || misses !== 8'd0 || busy !== 1'b0 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_up: mole=%b score=%0d misses=%0d busy=%b over=%b want all 0",
               mole, score, misses, busy, game_over);
    end
    repeat (10) @(negedge clock);
    total++;
    if (mole !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: mole=%b busy=%b want 0 0", mole, busy);
    end
    start_game();
    run_round(-1, -1, 2, 1'b0);
    for (int r = 1; r < int'(RND); r++) run_round(5, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    int mode, c, w;
    for (int gm = 0; gm < 3; gm++) begin
      start_game();
      for (int r = 0; r < int'(RND); r++) begin
        mode = int'($urandom_range(0, 3));
        c = -1; w = -1;
        case (mode)
          1: c = int'($urandom_range(0, UPC - 1));
          2: begin
            w = int'($urandom_range(0, UPC - 2));
            c = int'($urandom_range(w + 1, UPC - 1));
          end
          3: w = int'($urandom_range(0, UPC - 1));
          default: ;
        endcase
        run_round(c, w, int'($urandom_range(1, GAPC)), 1'b1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_hit();
    test_wrong_press();
    test_reset_mid_up();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mole_game_fsm.md
# mole_game_fsm

Round controller for the Whack-A-Mole game, directly downstream of the per-button `debouncer` instances. It consumes their one-cycle `pulse` outputs, picks a random hole each round, drives the one-hot mole LEDs, and judges hits, misses and timeouts. It accumulates score and miss counts and flags game over after a fixed number of rounds.

## Interface
- `NUM_HOLES`, 4: number of holes; power of two, 2–8.
- `UP_CYCLES`, 1000: maximum clock cycles a mole stays up (≥2).
- `GAP_CYCLES`, 200: clock cycles between rounds with no mole lit (≥1).
- `ROUNDS`, 16: rounds per game; 1–255.

- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse (debounced) that begins a game.
- `hit_pulse` in NUM_HOLES: one-cycle debounced pulses, one bit per hole button.
- `mole` out NUM_HOLES: one-hot active mole, or all zero.
- `score` out 8: rounds won this game.
- `misses` out 8: rounds lost this game.
- `busy` out 1: game in progress (GAP or UP).
- `game_over` out 1: high in DONE.

## Operation
- Reset values:
  - State is IDLE.
  - `mole`=0, `score`=0, `misses`=0, `busy`=0, `game_over`=0.
  - Round counter is 0, timer is 0.
  - LFSR is 8'hA5.
- LFSR:
  - 8-bit Fibonacci; each cycle shifts left with bit0 = l[7]^l[5]^l[4]^l[3].
  - Free-runs in every state. Only reset reseeds it.
  - Hole index = low log2(NUM_HOLES) bits of the LFSR at the GAP→UP edge.
- IDLE:
  - `start` clears score, misses and round counter, loads timer with GAP_CYCLES-1, and moves to GAP.
- GAP:
  - `mole`=0. The timer decrements each cycle.
  - When the timer equals 0: latch the hole, set `mole` one-hot, load timer with UP_CYCLES-1, move to UP.
- UP, checked in priority order:
  1. Hit: `hit_pulse` == `mole` exactly → `score`+1, end round.
  2. Wrong press: `hit_pulse` ≠ 0 and ≠ `mole` → handled per Configuration.
  3. Timeout: timer == 0 with no hit → `misses`+1, end round.
  4. Otherwise the timer decrements.
- End of round:
  - `mole`←0 and round counter +1.
  - If the new count equals ROUNDS, go to DONE. Otherwise load timer with GAP_CYCLES-1 and go to GAP.
- DONE:
  - `game_over`=1; score and misses hold.
  - `start` behaves as in IDLE: clears counts and goes to GAP with `game_over`←0.
- `start` in GAP or UP is ignored. `hit_pulse` in IDLE, GAP or DONE is ignored.
- Invariant: score + misses == round counter ≤ ROUNDS. No wrap is possible.
- `reset` asserted in any state returns all reset values on the next edge, overriding all other inputs.

## Timing
- All outputs are registered. Output changes appear one edge after the deciding input cycle.
- `busy` is high in GAP and UP.
- Start to mole:
  - `start` sampled at edge k → GAP from k+1.
  - `mole` goes high at edge k+GAP_CYCLES.
- Gap length: every GAP phase, including the first, lasts exactly GAP_CYCLES cycles.
- Mole up time: `mole` is high for exactly UP_CYCLES cycles if no press occurs.
- Timeout: the miss increments on the same edge that clears `mole`.
- Hit response: a hit in cycle n updates `score` and clears `mole` at edge n+1.
- Simultaneous events:
  - A hit in the timer==0 cycle counts as a hit, not a timeout.
  - Several hit bits set together (≠ `mole`) count as a wrong press.
- `game_over` rises on the same edge as the final score/miss update.

## Configuration
- `STRICT_PENALTY_EN`:
  - Defined: a wrong press in UP increments `misses` and ends the round immediately.
  - Undefined: wrong presses are ignored; the mole stays up and the timer keeps running.
- No other behaviour changes with the macro.

## Test plan
Bench parameters: UP_CYCLES=20, GAP_CYCLES=5, ROUNDS=4, NUM_HOLES=4. The bench runs a reference LFSR model.

- Reset, then hold `start`=0 for 50 cycles → `mole`=0, `busy`=0, `score`=`misses`=0 throughout.
- `start` pulse, then never press → each `mole` one-hot matches the model and stays up 20 cycles. After 4 rounds: `misses`=4, `score`=0, `game_over`=1, `busy`=0.
- `start`, then press the correct hole 3 cycles after each `mole` rise → `mole` clears next edge. After 4 rounds: `score`=4, `misses`=0, `game_over`=1.
- Wrong press, checked with and without the macro:
  - Without `STRICT_PENALTY_EN`: a wrong hole pressed 2 cycles into UP is ignored; the round still times out and `misses`=1.
  - With `STRICT_PENALTY_EN`: the same press makes `misses`=1 and clears `mole` at the next edge.
- Correct press in the timer==0 cycle → `score`+1, `misses` unchanged.
- Assert `reset` mid-UP with `score`=2 → next edge: `mole`=0, `score`=0, state IDLE. A `start` pulse in GAP is ignored.
